// File: rtl/ula_arb_pkg.sv
// Shared definitions for the two-requester ULA arbiter.
// Covers the FSM state encoding, the legal ULA operation codes and the latched request payload.
package ula_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_SLT = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR = 3'b111;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } ula_req_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/ula.sv
// Combinational 8-bit ULA.
// Arithmetic wraps modulo 256 and SLT compares unsigned; illegal codes produce 0x00 with the zero flag set.
module ula
  import ula_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              illegal_o
);

  always_comb begin
    result_o  = '0;
    illegal_o = !is_legal_op(op_i);
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_SLT:  result_o = DATA_W'(a_i < b_i);
      OP_XOR:  result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter that shares one ULA between two requesters.
// Each operation passes through IDLE -> EXEC -> RESP, so the block completes at most one operation every three cycles.
module ula_arbiter
  import ula_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  ula_req_t          op_q, op_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic              busy_q, busy_d;

  logic              grant_c;
  logic              accept_c;
  ula_req_t          req0_bus, req1_bus;
  logic [DATA_W-1:0] ula_result;
  logic              ula_zero;
  logic              ula_illegal;

  assign req0_bus = '{a: req0_a, b: req0_b, op: req0_op};
  assign req1_bus = '{a: req1_a, b: req1_b, op: req1_op};

  // On a tie, grant the requester that did not win the previous acceptance.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant_q;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
    accept_c = rst_n && (state_q == ST_IDLE) && (req0_valid || req1_valid);
  end

  assign req0_ready = accept_c && !grant_c;
  assign req1_ready = accept_c && grant_c;

  ula u_ula (
    .a_i      (op_q.a),
    .b_i      (op_q.b),
    .op_i     (op_q.op),
    .result_o (ula_result),
    .zero_o   (ula_zero),
    .illegal_o(ula_illegal)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    result_d     = result_q;
    zero_d       = zero_q;
    illegal_d    = illegal_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d         = grant_c ? req1_bus : req0_bus;
          id_d         = grant_c;
          last_grant_d = grant_c;
          busy_d       = 1'b1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d    = ula_result;
        zero_d      = ula_zero;
        illegal_d   = ula_illegal;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Returning to IDLE here, not accepting, keeps one full idle cycle between operations.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      illegal_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      illegal_q    <= illegal_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_illegal = illegal_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Scoreboard bench for ula_arbiter.
// Stimulus pushes hand-computed responses in expected grant order; a negedge monitor checks each response handshake.
module tb_ula_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic [2:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic [2:0] req1_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_illegal, busy;

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       zero;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Round-robin vectors: req0 then req1, four each.
  logic [7:0] v0_a  [4] = '{8'h0C, 8'hF0, 8'h01, 8'hAA};
  logic [7:0] v0_b  [4] = '{8'h30, 8'h0F, 8'h02, 8'h55};
  logic [2:0] v0_op [4] = '{3'b011, 3'b010, 3'b101, 3'b111};
  logic [7:0] e0_r  [4] = '{8'h3C, 8'h00, 8'h01, 8'hFF};
  logic       e0_z  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] v1_a  [4] = '{8'h2A, 8'h10, 8'hFF, 8'h80};
  logic [7:0] v1_b  [4] = '{8'h2A, 8'h20, 8'h01, 8'h7F};
  logic [2:0] v1_op [4] = '{3'b001, 3'b001, 3'b000, 3'b101};
  logic [7:0] e1_r  [4] = '{8'h00, 8'hF0, 8'h00, 8'h00};
  logic       e1_z  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  ula_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_illegal(rsp_illegal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    if (!id) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic push(input bit id, input logic [7:0] res, input bit zero, input bit ill);
    exp_t e;
    e.id = id; e.res = res; e.zero = zero; e.ill = ill;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the given requester to be granted; cyc counts negedges waited.
  task automatic wait_ready(input bit id, output int cyc);
    logic  rdy;
    string nm;
    nm  = id ? "req1_accept" : "req0_accept";
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      rdy = id ? req1_ready : req0_ready;
    end while (!rdy && cyc < 20);
    chk(nm, 32'(rdy), 32'd1);
    chk({nm, "_other_ready"}, 32'(id ? req0_ready : req1_ready), 32'd0);
  endtask

  // Scoreboard monitor: compare every response handshake against the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d result=0x%0h with no response expected at %0t",
                 rsp_id, rsp_result, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_payload", 32'({rsp_id, rsp_result, rsp_zero, rsp_illegal}), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 8'h05, 8'h03, 3'b000);
    set_req(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);

    // Reset state, with a pending request that must not see ready.
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, busy}), 32'd0);
    chk("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);

    // Single req0 add, accepted in the first cycle out of reset.
    @(posedge clk); #1 rst_n = 1'b1;
    wait_ready(1'b0, cyc);
    chk("first_accept_cycle", 32'(cyc), 32'd1);
    push(1'b0, 8'h08, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'hEE, 8'hEE, 3'b100);
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("post_handshake_valid", 32'(rsp_valid), 32'd0);
    chk("post_handshake_busy", 32'(busy), 32'd0);

    // Fresh reset so the first tie goes to req0, then four alternating pairs.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    set_req(1'b0, 1'b1, v0_a[0], v0_b[0], v0_op[0]);
    set_req(1'b1, 1'b1, v1_a[0], v1_b[0], v1_op[0]);
    for (int k = 0; k < 8; k++) begin
      bit id;
      int idx;
      id  = k[0];
      idx = k / 2;
      wait_ready(id, cyc);
      chk("rr_accept_spacing", 32'(cyc), (k == 0) ? 32'd1 : 32'd3);
      if (!id) push(1'b0, e0_r[idx], e0_z[idx], 1'b0);
      else     push(1'b1, e1_r[idx], e1_z[idx], 1'b0);
      @(posedge clk); #1;
      if (idx < 3) begin
        if (!id) set_req(1'b0, 1'b1, v0_a[idx+1], v0_b[idx+1], v0_op[idx+1]);
        else     set_req(1'b1, 1'b1, v1_a[idx+1], v1_b[idx+1], v1_op[idx+1]);
      end else begin
        set_req(id, 1'b0, 8'h00, 8'h00, 3'b000);
      end
    end
    repeat (3) @(negedge clk);

    // Backpressure: hold rsp_ready low while both requesters wait.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 8'h10, 8'h05, 3'b000);
    wait_ready(1'b1, cyc);
    push(1'b1, 8'h15, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 8'h0F, 8'hF0, 3'b100);
    set_req(1'b1, 1'b1, 8'h03, 8'h01, 3'b001);
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_payload", 32'({rsp_id, rsp_result}), 32'h115);
      chk("bp_ready_low", 32'({req0_ready, req1_ready}), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("no_bypass_ready", 32'({req0_ready, req1_ready}), 32'd0);

    // Illegal op from req0 wins the tie the cycle after the handshake.
    wait_ready(1'b0, cyc);
    chk("resume_accept_cycle", 32'(cyc), 32'd1);
    push(1'b0, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    wait_ready(1'b1, cyc);
    chk("req1_after_illegal_spacing", 32'(cyc), 32'd3);
    push(1'b1, 8'h02, 1'b0, 1'b0);
    @(posedge clk); #1 set_req(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
    repeat (3) @(negedge clk);

    // Reset pulse while a response is held: it must vanish and never reappear.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 8'h01, 8'h01, 3'b000);
    wait_ready(1'b1, cyc);
    @(posedge clk); #1 set_req(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(rsp_valid), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 8'h07, 8'h07, 3'b001);
    set_req(1'b1, 1'b1, 8'h33, 8'h0F, 3'b011);
    wait_ready(1'b0, cyc);
    push(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    wait_ready(1'b1, cyc);
    push(1'b1, 8'h3F, 1'b0, 1'b0);
    @(posedge clk); #1 set_req(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_arbiter.md
ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req0_valid  input  1  requester 0 holds an operation.
REQ-004 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-005 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-006 req0_op  input  3  requester 0 operation code (ULA encoding).
REQ-007 req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions and widths as requester 0, for requester 1.
REQ-008 rsp_valid  output  1  response held.
REQ-009 rsp_ready  input  1  consumer takes response.
REQ-010 rsp_id  output  1  requester that owns the response.
REQ-011 rsp_result  output  8  registered ULA result.
REQ-012 rsp_zero  output  1  registered zero flag.
REQ-013 rsp_illegal  output  1  operation code was not 000/001/010/011/101/111.
REQ-014 busy  output  1  FSM not in IDLE.

Function
REQ-015 FSM SHALL have states IDLE, EXEC, RESP.
REQ-016 IDLE: with at least one valid, arbiter SHALL assert exactly one reqN_ready combinationally, latch that requester's a/b/op and id, and go to EXEC next edge.
REQ-017 Both valid in IDLE: grant SHALL go to the requester not granted last (round-robin); last_grant SHALL update only on acceptance.
REQ-018 reqN_ready SHALL be 0 in EXEC and RESP and whenever reqN_valid is 0.
REQ-019 EXEC: latched operands SHALL drive the shared ULA; result, zero flag, illegal flag SHALL be registered at end of EXEC; next state RESP.
REQ-020 Latency: acceptance at edge T -> rsp_valid high after edge T+2.
REQ-021 RESP: rsp_valid=1, outputs stable until edge with rsp_ready=1; then IDLE (rsp_valid low next cycle).
REQ-022 No bypass: new request SHALL NOT be accepted in the cycle rsp_ready handshakes; earliest acceptance is the following IDLE cycle (throughput one op per 3 cycles min).
REQ-023 Arithmetic: 8-bit wrap-around per ULA (add/sub modulo 256, SLT unsigned, XOR on 111); illegal codes give result 0x00, zero 1, illegal 1.
REQ-024 Requester dropping valid after acceptance SHALL not affect the operation in flight.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, rsp_valid=0, rsp_id=0, rsp_result=0x00, rsp_zero=0, rsp_illegal=0, busy=0, both ready=0, last_grant=1 (requester 0 wins first tie).
REQ-026 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response issued after release.
REQ-027 First acceptance possible in first cycle with rst_n high.

Structure
REQ-028 Shared package ula_arb_pkg SHALL hold state encoding (IDLE/EXEC/RESP) and the six legal operation-code constants.
REQ-029 Block SHALL instantiate the existing ULA module once as its only sub-module; no second ALU copy.

Verification
REQ-030 Single req0: a=0x05, b=0x03, op=000 -> rsp_valid 2 cycles after accept, id=0, result=0x08, zero=0.
REQ-031 Both valid after reset, req1 op=001 a=b=0x2A, req0 op=011 -> req0 first; then req1: result=0x00, zero=1; grants alternate over 4 back-to-back pairs.
REQ-032 Wrap and SLT: add 0xFF+0x01 -> 0x00, zero=1; op=101 a=0x80 b=0x7F -> 0x00; a=0x01 b=0x02 -> 0x01.
REQ-033 Backpressure: rsp_ready low 5 cycles -> rsp_valid, result, id stable; both ready stay 0; accept resumes cycle after handshake.
REQ-034 Illegal op=100 a=0x0F b=0xF0 -> result 0x00, zero=1, illegal=1.
REQ-035 rst_n pulse during RESP -> rsp_valid low immediately; no response after release; next tie grants requester 0.
